// File: rtl/pll_reset_sequencer.sv
// Lock qualification and synchronous reset sequencing behind the system PLL.
// Optional feature macro: LOCK_LOSS_COUNT_EN builds the saturating lock-loss counter.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 locked,
    output logic                 locked_sync,
    output logic                 sys_reset,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] lock_lost_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // The observation edge that moves us out of WAIT_LOCK is already the first
    // stable sample, so the stable window closes when cnt reaches LOCK_STABLE_CYCLES-1.
    localparam logic [19:0] QUAL_LAST  = 20'(LOCK_STABLE_CYCLES - 1);
    localparam logic [19:0] HOLD_LAST  = 20'(RESET_HOLD_CYCLES);
    localparam bit          QUAL_SHORT = (LOCK_STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_sync_s;
    state_t                 state_r;
    state_t                 state_next_s;
    logic [19:0]            cnt_r;
    logic [19:0]            cnt_next_s;
    logic                   sys_reset_r;
    logic                   ready_r;

    assign locked_sync_s = sync_r[SYNC_STAGES-1];
    assign locked_sync   = locked_sync_s;
    assign sys_reset     = sys_reset_r;
    assign ready         = ready_r;

    // Next-state and shared counter decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            WAIT_LOCK: begin
                if (locked_sync_s) begin
                    state_next_s = QUAL_SHORT ? HOLD : QUALIFY;
                    cnt_next_s   = 20'd1;
                end else begin
                    cnt_next_s   = 20'd0;
                end
            end
            QUALIFY: begin
                if (!locked_sync_s) begin
                    state_next_s = WAIT_LOCK;
                    cnt_next_s   = 20'd0;
                end else if (cnt_r == QUAL_LAST) begin
                    state_next_s = HOLD;
                    cnt_next_s   = 20'd1;
                end else begin
                    cnt_next_s   = cnt_r + 20'd1;
                end
            end
            HOLD: begin
                if (!locked_sync_s) begin
                    state_next_s = WAIT_LOCK;
                    cnt_next_s   = 20'd0;
                end else if (cnt_r == HOLD_LAST) begin
                    state_next_s = RUN;
                end else begin
                    cnt_next_s   = cnt_r + 20'd1;
                end
            end
            RUN: begin
                if (!locked_sync_s) begin
                    state_next_s = WAIT_LOCK;
                    cnt_next_s   = 20'd0;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = WAIT_LOCK;
                cnt_next_s   = 20'd0;
            end
        endcase
    end

    // Synchroniser, state, counter and outputs registered from the next state.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_r      <= '0;
            state_r     <= WAIT_LOCK;
            cnt_r       <= 20'd0;
            sys_reset_r <= 1'b1;
            ready_r     <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], locked};
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            sys_reset_r <= (state_next_s != RUN);
            ready_r     <= (state_next_s == RUN);
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic                 lost_event_s;
    logic [CNT_WIDTH-1:0] lost_cnt_r;

    // Only a drop while running counts; qualification failures do not.
    assign lost_event_s = (state_r == RUN) && !locked_sync_s;

    // Saturating lock-loss counter.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lost_cnt_r <= '0;
        end else if (lost_event_s && (lost_cnt_r != {CNT_WIDTH{1'b1}})) begin
            lost_cnt_r <= lost_cnt_r + CNT_WIDTH'(1);
        end else begin
            lost_cnt_r <= lost_cnt_r;
        end
    end

    assign lock_lost_count = lost_cnt_r;
`else
    assign lock_lost_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (SYNC_STAGES=2, LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3).
module tb_pll_reset_sequencer;

`ifdef LOCK_LOSS_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       locked   = 1'b0;
    logic       locked_sync;
    logic       sys_reset;
    logic       ready;
    logic [1:0] lock_lost_count;

    int total = 0;
    int bad   = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(4), .RESET_HOLD_CYCLES(3), .CNT_WIDTH(2)
    ) dut (
        .clock_in(clock_in), .reset(reset), .locked(locked), .locked_sync(locked_sync),
        .sys_reset(sys_reset), .ready(ready), .lock_lost_count(lock_lost_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    function automatic logic [1:0] exp_cnt(input int v);
        return CNT_ON ? 2'(v) : 2'd0;
    endfunction

    task automatic test_reset();
        reset = 1'b1; locked = 1'b0;
        tick(3);
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", ready); end
        total++; if (locked_sync !== 1'b0) begin bad++; $display("FAIL reset_locked_sync got %b want 0", locked_sync); end
        total++; if (lock_lost_count !== 2'd0) begin bad++; $display("FAIL reset_count got %0d want 0", lock_lost_count); end
        reset = 1'b0;
    endtask

    task automatic test_release();
        locked = 1'b1;
        tick(1);
        total++; if (locked_sync !== 1'b0) begin bad++; $display("FAIL rel_sync_e0 got %b want 0", locked_sync); end
        tick(1);
        total++; if (locked_sync !== 1'b1) begin bad++; $display("FAIL rel_sync_e1 got %b want 1", locked_sync); end
        for (int k = 2; k <= 7; k++) begin
            tick(1);
            total++; if (sys_reset !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL rel_hold_e%0d got sys_reset=%b ready=%b want 1/0", k, sys_reset, ready); end
        end
        tick(1);
        total++; if (sys_reset !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL rel_e8 got sys_reset=%b ready=%b want 0/1", sys_reset, ready); end
    endtask

    task automatic test_glitch();
        reset = 1'b1; tick(1); reset = 1'b0;
        locked = 1'b1; tick(2);
        locked = 1'b0; tick(1);
        locked = 1'b1; tick(1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL glitch_hold_r%0d got %b want 1", k, sys_reset); end
        end
        tick(1);
        total++; if (sys_reset !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL glitch_release got sys_reset=%b ready=%b want 0/1", sys_reset, ready); end
        total++; if (lock_lost_count !== 2'd0) begin bad++; $display("FAIL glitch_count got %0d want 0", lock_lost_count); end
    endtask

    task automatic test_lock_loss();
        locked = 1'b0;
        tick(1);
        total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL loss_f0 got %b want 0", sys_reset); end
        tick(1);
        total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL loss_f1 got %b want 0", sys_reset); end
        tick(1);
        total++; if (sys_reset !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL loss_f2 got sys_reset=%b ready=%b want 1/0", sys_reset, ready); end
        total++; if (lock_lost_count !== exp_cnt(1)) begin bad++; $display("FAIL loss_count got %0d want %0d", lock_lost_count, exp_cnt(1)); end
        locked = 1'b1;
        tick(1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL relock_hold_e%0d got %b want 1", k, sys_reset); end
        end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL relock_release got ready=%b want 1", ready); end
    endtask

    task automatic test_saturation();
        reset = 1'b1; tick(1); reset = 1'b0;
        locked = 1'b1; tick(9);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL sat_start_ready got %b want 1", ready); end
        for (int i = 0; i < 5; i++) begin
            locked = 1'b0; tick(3);
            total++; if (lock_lost_count !== exp_cnt((i < 2) ? i + 1 : 3)) begin bad++; $display("FAIL sat_count_%0d got %0d want %0d", i, lock_lost_count, exp_cnt((i < 2) ? i + 1 : 3)); end
            total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL sat_sys_reset_%0d got %b want 1", i, sys_reset); end
            locked = 1'b1; tick(9);
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL sat_relock_%0d got ready=%b want 1", i, ready); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(1); reset = 1'b0;
        locked = 1'b1; tick(6);
        total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL mid_hold_pre got %b want 1", sys_reset); end
        reset = 1'b1; tick(1); reset = 1'b0;
        total++; if (sys_reset !== 1'b1 || ready !== 1'b0 || locked_sync !== 1'b0 || lock_lost_count !== 2'd0) begin bad++; $display("FAIL mid_hold_reset got sys_reset=%b ready=%b sync=%b count=%0d want 1/0/0/0", sys_reset, ready, locked_sync, lock_lost_count); end
        tick(1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL mid_hold_requal_e%0d got %b want 1", k, sys_reset); end
        end
        tick(1);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_hold_release got ready=%b want 1", ready); end
        locked = 1'b0; tick(3); locked = 1'b1; tick(9);
        total++; if (ready !== 1'b1 || lock_lost_count !== exp_cnt(1)) begin bad++; $display("FAIL mid_run_pre got ready=%b count=%0d want 1/%0d", ready, lock_lost_count, exp_cnt(1)); end
        reset = 1'b1; tick(1); reset = 1'b0;
        total++; if (sys_reset !== 1'b1 || ready !== 1'b0 || lock_lost_count !== 2'd0) begin bad++; $display("FAIL mid_run_reset got sys_reset=%b ready=%b count=%0d want 1/0/0", sys_reset, ready, lock_lost_count); end
        tick(1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL mid_run_requal_e%0d got %b want 1", k, sys_reset); end
        end
        tick(1);
        total++; if (sys_reset !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL mid_run_release got sys_reset=%b ready=%b want 0/1", sys_reset, ready); end
    endtask

    task automatic test_simultaneous();
        locked = 1'b0; tick(3); locked = 1'b1; tick(9);
        total++; if (lock_lost_count !== exp_cnt(1)) begin bad++; $display("FAIL simul_pre_count got %0d want %0d", lock_lost_count, exp_cnt(1)); end
        locked = 1'b0; tick(2);
        reset = 1'b1; tick(1); reset = 1'b0;
        total++; if (lock_lost_count !== 2'd0 || sys_reset !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL simul_edge got count=%0d sys_reset=%b ready=%b want 0/1/0", lock_lost_count, sys_reset, ready); end
        tick(2);
        total++; if (lock_lost_count !== 2'd0 || sys_reset !== 1'b1) begin bad++; $display("FAIL simul_after got count=%0d sys_reset=%b want 0/1", lock_lost_count, sys_reset); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_lock_loss();
        test_saturation();
        test_reset_mid();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
